issue_window_ctrl: RTL and testbench

//  3-wide in-order issue window between IF and ID of the superscalar pipe.

---
 rtl/issue_window_ctrl_pkg.sv | 18 +
 rtl/issue_window_ctrl_ram.sv | 33 +++
 rtl/issue_window_ctrl.sv | 105 ++++++++++
 tb/tb_issue_window_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_window_ctrl_pkg.sv
// rtl/issue_window_ctrl_pkg.sv - shared types and constants for the 3-wide issue window
package issue_window_ctrl_pkg;

    localparam int          ISSUE_WAYS  = 3;
    localparam int          ISSUE_DEPTH = 8;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } issue_entry_t;

    // Population count of a fetch mask; illegal masks still count their set bits.
    function automatic logic [1:0] popcount3(input logic [2:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
    endfunction

endpackage

// File: rtl/issue_window_ctrl_ram.sv
// rtl/issue_window_ctrl_ram.sv - circular entry storage, 3 write ports at tail+i, 3 comb reads at head+i
module issue_window_ctrl_ram
    import issue_window_ctrl_pkg::*;
#(
    parameter int  DEPTH = ISSUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                             clock,
    input  logic         [ISSUE_WAYS-1:0]    wr_en,
    input  logic         [PTR_W-1:0]         wr_ptr,
    input  issue_entry_t [ISSUE_WAYS-1:0]    wr_data,
    input  logic         [PTR_W-1:0]         rd_ptr,
    output issue_entry_t [ISSUE_WAYS-1:0]    rd_data
);

    issue_entry_t mem_q [DEPTH];

    // Storage is deliberately not reset: contents are don't-care while the slot is invalid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ISSUE_WAYS; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_ptr + PTR_W'(i)] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_WAYS; i++) begin
            rd_data[i] = mem_q[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/issue_window_ctrl.sv
// rtl/issue_window_ctrl.sv - 3-wide in-order issue window between IF and ID with hazard rollback
module issue_window_ctrl
    import issue_window_ctrl_pkg::*;
#(
    parameter int DEPTH = ISSUE_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [2:0]            if_valid,
    input  logic [2:0][31:0]      if_inst,
    input  logic [2:0][31:0]      if_pc,
    output logic                  if_ready,
    output logic [2:0]            id_valid,
    output logic [2:0][31:0]      id_inst,
    output logic [2:0][31:0]      id_pc,
    input  logic                  id_stall,
    input  logic [1:0]            rollback,
    output logic [CNT_W-1:0]      count,
    output logic [31:0]           rollback_cycles
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rbc_q, rbc_d;

    logic [1:0] presented, room, accepted, written;
    logic [ISSUE_WAYS-1:0]    wr_en;
    issue_entry_t [ISSUE_WAYS-1:0] wr_data;
    issue_entry_t [ISSUE_WAYS-1:0] rd_data;

    always_comb begin
        presented = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
        room      = 2'd3 - rollback;
        accepted  = id_stall ? 2'd0 : ((presented < room) ? presented : room);
        // Readiness comes from the registered count only, so a same-cycle accept never frees room.
        if_ready  = (count_q <= CNT_W'(DEPTH - 3));
        written   = (if_ready && !flush) ? popcount3(if_valid) : 2'd0;

        for (int i = 0; i < ISSUE_WAYS; i++) begin
            wr_en[i]        = (2'(i) < written);
            wr_data[i].inst = if_inst[i];
            wr_data[i].pc   = if_pc[i];
        end

        head_d  = head_q + PTR_W'(accepted);
        tail_d  = tail_q + PTR_W'(written);
        count_d = count_q - CNT_W'(accepted) + CNT_W'(written);
        rbc_d   = rbc_q;
        if ((rollback != 2'd0) && (count_q != '0) && !flush && !id_stall && (rbc_q != '1)) begin
            rbc_d = rbc_q + 32'd1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rbc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rbc_q   <= rbc_d;
        end
    end

    issue_window_ctrl_ram #(.DEPTH(DEPTH)) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_ptr  (tail_q),
        .wr_data (wr_data),
        .rd_ptr  (head_q),
        .rd_data (rd_data)
    );

    always_comb begin
        for (int i = 0; i < ISSUE_WAYS; i++) begin
            id_valid[i] = (count_q > CNT_W'(i));
            id_inst[i]  = id_valid[i] ? rd_data[i].inst : NOP;
            id_pc[i]    = id_valid[i] ? rd_data[i].pc   : 32'd0;
        end
    end

    assign count           = count_q;
    assign rollback_cycles = rbc_q;

    a_mask_contiguous: assert property (@(posedge clock) disable iff (!reset_n)
        (if_valid inside {3'b000, 3'b001, 3'b011, 3'b111}));
    a_no_rollback_on_stall: assert property (@(posedge clock) disable iff (!reset_n)
        !(id_stall && (rollback != 2'd0)));
    a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
        (count_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_issue_window_ctrl.sv
// tb/tb_issue_window_ctrl.sv - directed self-checking bench for issue_window_ctrl
module tb_issue_window_ctrl;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic [2:0]       if_valid = 3'b000;
    logic [2:0][31:0] if_inst = '0;
    logic [2:0][31:0] if_pc = '0;
    logic             if_ready;
    logic [2:0]       id_valid;
    logic [2:0][31:0] id_inst;
    logic [2:0][31:0] id_pc;
    logic             id_stall = 1'b1;
    logic [1:0]       rollback = 2'd0;
    logic [3:0]       count;
    logic [31:0]      rollback_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    issue_window_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .flush           (flush),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_stall        (id_stall),
        .rollback        (rollback),
        .count           (count),
        .rollback_cycles (rollback_cycles)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic drive_fetch(input int n, input logic [31:0] base);
        if_valid = (n == 0) ? 3'b000 : (n == 1) ? 3'b001 : (n == 2) ? 3'b011 : 3'b111;
        for (int i = 0; i < 3; i++) begin
            if_pc[i]   = base + 32'(4 * i);
            if_inst[i] = inst_of(base + 32'(4 * i));
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (id_valid !== 3'b000) begin bad++; $display("FAIL reset_id_valid got=%b exp=000", id_valid); end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
        total++; if (rollback_cycles !== 32'd0) begin bad++; $display("FAIL reset_rbc got=%0d exp=0", rollback_cycles); end
        total++; if (id_pc !== 96'd0 || id_inst !== {TB_NOP, TB_NOP, TB_NOP}) begin
            bad++; $display("FAIL reset_nop got pc=%h inst=%h", id_pc, id_inst);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_push3();
        id_stall = 1'b1; rollback = 2'd0;
        drive_fetch(3, 32'h0);
        step();
        drive_fetch(0, 32'h0);
        total++; if (id_valid !== 3'b111) begin bad++; $display("FAIL push3_valid got=%b exp=111", id_valid); end
        total++; if (id_pc !== {32'h8, 32'h4, 32'h0}) begin bad++; $display("FAIL push3_pc got=%h", id_pc); end
        total++; if (id_inst !== {inst_of(32'h8), inst_of(32'h4), inst_of(32'h0)}) begin
            bad++; $display("FAIL push3_inst got=%h", id_inst);
        end
        total++; if (count !== 4'd3) begin bad++; $display("FAIL push3_count got=%0d exp=3", count); end
    endtask

    task automatic test_rollback2();
        id_stall = 1'b0; rollback = 2'd2;
        step();
        rollback = 2'd0; id_stall = 1'b1;
        total++; if (id_valid !== 3'b011) begin bad++; $display("FAIL rb2_valid got=%b exp=011", id_valid); end
        total++; if (id_pc !== {32'h0, 32'h8, 32'h4}) begin bad++; $display("FAIL rb2_pc got=%h", id_pc); end
        total++; if (id_inst[2] !== TB_NOP) begin bad++; $display("FAIL rb2_nop got=%h exp=%h", id_inst[2], TB_NOP); end
        total++; if (count !== 4'd2) begin bad++; $display("FAIL rb2_count got=%0d exp=2", count); end
        total++; if (rollback_cycles !== 32'd1) begin bad++; $display("FAIL rb2_rbc got=%0d exp=1", rollback_cycles); end
    endtask

    task automatic test_fill();
        drive_fetch(3, 32'h100);
        step();
        drive_fetch(1, 32'h10C);
        step();
        total++; if (count !== 4'd6) begin bad++; $display("FAIL fill_count got=%0d exp=6", count); end
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", if_ready); end
        drive_fetch(3, 32'h200);
        step();
        drive_fetch(0, 32'h0);
        total++; if (count !== 4'd6) begin bad++; $display("FAIL fill_drop_count got=%0d exp=6", count); end
        total++; if (id_pc !== {32'h100, 32'h8, 32'h4}) begin bad++; $display("FAIL fill_head got=%h", id_pc); end
        id_stall = 1'b0;
        step();
        total++; if (id_pc !== {32'h10C, 32'h108, 32'h104} || count !== 4'd3) begin
            bad++; $display("FAIL fill_drain1 got pc=%h count=%0d", id_pc, count);
        end
        step();
        total++; if (count !== 4'd0 || id_valid !== 3'b000 || id_pc !== 96'd0) begin
            bad++; $display("FAIL fill_drain2 got count=%0d valid=%b pc=%h", count, id_valid, id_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        id_stall = 1'b1;
        drive_fetch(3, 32'h1000);
        step();
        drive_fetch(2, 32'h100C);
        step();
        id_stall = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            drive_fetch(3, 32'h1014 + 32'(12 * (k - 1)));
            step();
            e = 32'h1000 + 32'(12 * k);
            total++; if (id_pc !== {e + 32'd8, e + 32'd4, e} || count !== 4'd5) begin
                bad++; $display("FAIL wrap_iter%0d got pc=%h count=%0d exp head=%h count=5", k, id_pc, count, e);
            end
        end
        drive_fetch(0, 32'h0);
        step();
        total++; if (id_pc !== {32'h0, 32'h1088, 32'h1084} || count !== 4'd2) begin
            bad++; $display("FAIL wrap_tail got pc=%h count=%0d", id_pc, count);
        end
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        id_stall = 1'b1;
        drive_fetch(3, 32'h3000);
        step();
        id_stall = 1'b0; rollback = 2'd1; flush = 1'b1;
        drive_fetch(3, 32'h3100);
        step();
        flush = 1'b0; rollback = 2'd0;
        drive_fetch(0, 32'h0);
        total++; if (count !== 4'd0 || id_valid !== 3'b000) begin
            bad++; $display("FAIL flush_empty got count=%0d valid=%b", count, id_valid);
        end
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", if_ready); end
        total++; if (rollback_cycles !== 32'd1) begin bad++; $display("FAIL flush_rbc got=%0d exp=1", rollback_cycles); end
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_discard got=%0d exp=0", count); end
    endtask

    task automatic test_rollback_edges();
        id_stall = 1'b1;
        drive_fetch(1, 32'h3200);
        step();
        drive_fetch(0, 32'h0);
        total++; if (id_pc[0] !== 32'h3200 || id_valid !== 3'b001) begin
            bad++; $display("FAIL edge_single got pc0=%h valid=%b", id_pc[0], id_valid);
        end
        id_stall = 1'b0; rollback = 2'd1;
        step();
        total++; if (count !== 4'd0 || rollback_cycles !== 32'd2) begin
            bad++; $display("FAIL edge_rb1 got count=%0d rbc=%0d exp 0/2", count, rollback_cycles);
        end
        rollback = 2'd2;
        step();
        total++; if (rollback_cycles !== 32'd2) begin bad++; $display("FAIL edge_rb_empty got=%0d exp=2", rollback_cycles); end
        rollback = 2'd0; id_stall = 1'b1;
        drive_fetch(1, 32'h2004);
        step();
        drive_fetch(0, 32'h0);
        id_stall = 1'b0; rollback = 2'd3;
        step();
        rollback = 2'd0; id_stall = 1'b1;
        total++; if (count !== 4'd1 || id_pc[0] !== 32'h2004) begin
            bad++; $display("FAIL edge_rb3 got count=%0d pc0=%h exp 1/2004", count, id_pc[0]);
        end
        total++; if (rollback_cycles !== 32'd3) begin bad++; $display("FAIL edge_rb3_rbc got=%0d exp=3", rollback_cycles); end
    endtask

    task automatic test_reset_mid();
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (count !== 4'd0 || id_valid !== 3'b000 || rollback_cycles !== 32'd0) begin
            bad++; $display("FAIL midreset got count=%0d valid=%b rbc=%0d", count, id_valid, rollback_cycles);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        total++; if (count !== 4'd0 || if_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_release got count=%0d ready=%b", count, if_ready);
        end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_rollback2();
        test_fill();
        test_wrap();
        test_flush();
        test_rollback_edges();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
